// File: rtl/alu_pkg.sv
// Shared ALU op encoding and helpers, used by the arbiter, the ALU and the decoder.
package alu_pkg;

  localparam int unsigned ALUOP_W = 4;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } aluop_e;

  localparam logic [ALUOP_W-1:0] ALUOP_MAX = 4'd10;

  // Codes above the last defined op are reserved and reported as errors.
  function automatic logic aluop_illegal(input logic [ALUOP_W-1:0] op);
    return op > ALUOP_MAX;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; shift amounts use the full operand B.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [XLEN-1:0]    opr_a,
  input  logic [XLEN-1:0]    opr_b,
  output logic [XLEN-1:0]    res
);

  always_comb begin
    res = '0;
    case (aluop)
      ALU_ADD:   res = opr_a + opr_b;
      ALU_SUB:   res = opr_a - opr_b;
      ALU_SLL:   res = opr_a << opr_b;
      ALU_SLT:   res = XLEN'($signed(opr_a) < $signed(opr_b));
      ALU_SLTU:  res = XLEN'(opr_a < opr_b);
      ALU_XOR:   res = opr_a ^ opr_b;
      ALU_SRL:   res = opr_a >> opr_b;
      ALU_SRA:   res = XLEN'($signed(opr_a) >>> opr_b);
      ALU_OR:    res = opr_a | opr_b;
      ALU_AND:   res = opr_a & opr_b;
      ALU_PASSB: res = opr_b;
      default:   res = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one ALU between two requesters, with a
// registered, id-tagged result and per-requester issue counters.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [ALUOP_W-1:0] req0_aluop,
  input  logic [XLEN-1:0]    req0_opr_a,
  input  logic [XLEN-1:0]    req0_opr_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [ALUOP_W-1:0] req1_aluop,
  input  logic [XLEN-1:0]    req1_opr_a,
  input  logic [XLEN-1:0]    req1_opr_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [XLEN-1:0]    rsp_res,
  output logic               rsp_err,
  output logic [CNT_W-1:0]   cnt0,
  output logic [CNT_W-1:0]   cnt1
);

  logic               last_grant;
  logic               can_accept_c;
  logic               gnt0_c;
  logic               gnt1_c;
  logic               accept_c;
  logic [ALUOP_W-1:0] op_c;
  logic [XLEN-1:0]    opr_a_c;
  logic [XLEN-1:0]    opr_b_c;
  logic [XLEN-1:0]    alu_res_c;
  logic               illegal_c;

  // Result slot frees up when empty or being drained this cycle.
  assign can_accept_c = !rsp_valid || rsp_ready;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt0_c = last_grant;
      gnt1_c = !last_grant;
    end else begin
      gnt0_c = req0_valid;
      gnt1_c = req1_valid;
    end
  end

  assign req0_ready = can_accept_c && gnt0_c;
  assign req1_ready = can_accept_c && gnt1_c;
  assign accept_c   = req0_ready || req1_ready;

  always_comb begin
    op_c    = req0_aluop;
    opr_a_c = req0_opr_a;
    opr_b_c = req0_opr_b;
    if (gnt1_c) begin
      op_c    = req1_aluop;
      opr_a_c = req1_opr_a;
      opr_b_c = req1_opr_b;
    end
  end

  assign illegal_c = aluop_illegal(op_c);

  alu #(
    .XLEN (XLEN)
  ) u_alu (
    .aluop (op_c),
    .opr_a (opr_a_c),
    .opr_b (opr_b_c),
    .res   (alu_res_c)
  );

  // Result register: load on accept, clear valid on a drain without refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_res   <= '0;
      rsp_err   <= 1'b0;
    end else if (accept_c) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gnt1_c;
      rsp_res   <= illegal_c ? '0 : alu_res_c;
      rsp_err   <= illegal_c;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept_c) begin
      last_grant <= gnt1_c;
    end
  end

  // Issue counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (req0_ready) cnt0 <= cnt0 + CNT_W'(1);
      if (req1_ready) cnt1 <= cnt1 + CNT_W'(1);
    end
  end

endmodule
